id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised pipelined successor to the single-cycle decode stage. Extracts register/immediate fields and reads a parametrised GPR file with write-through bypass. Builds operand A/B and a destination index, detects load-use hazards, and registers everything into a valid/ready ID/EX pipeline register. Sits between the fetch stage and the EX stage; the control decoder stays external and drives the ctl_* inputs combinationally from if_instr.

Parameters:
DATA_W, 32, GPR and operand width (>=16)
NUM_REGS, 32, GPR count (power of 2, <=32); AW = log2(NUM_REGS)
REG0_ZERO, 1, 1: register 0 reads 0 and ignores writes
BYPASS, 1, 1: same-cycle writeback forwarded to reads
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  ID accepts the instruction this cycle
if_instr  in  [0:31]  instruction, bit 0 = MSB
if_pc  in  [0:31]  PC of if_instr
ctl_alu_src  in  1  1: operand B = extended immediate
ctl_ext_op  in  1  1: sign-extend, 0: zero-extend
ctl_imm_zero  in  1  force immediate to 0
ctl_reg_dst  in  1  1: dst = rd, 0: dst = rt
ctl_link  in  1  dst = NUM_REGS-1 (overrides ctl_reg_dst)
ctl_reg_wr  in  1  instruction writes a GPR
ctl_mem_rd  in  1  instruction is a load
flush  in  1  kill the ID instruction and the EX-register contents
wb_we  in  1  writeback enable
wb_addr  in  AW  writeback index
wb_data  in  DATA_W  writeback data
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ready  in  1  EX consumes the register contents
ex_operand_a  out  DATA_W  GPR[rs]
ex_operand_b  out  DATA_W  immediate or GPR[rt]
ex_store_data  out  DATA_W  GPR[rt], always
ex_dst  out  AW  destination index
ex_reg_wr, ex_mem_rd  out  1 each  registered controls
ex_pc  out  [0:31]  registered PC
stall_count  out  STALL_CNT_W  hazard-stall cycles, saturating

Behaviour:
- Fields: rs = instr[6:10], rt = [11:15], rd = [16:20], truncated to the low AW bits; imm16 = ctl_imm_zero ? 0 : instr[16:31].
- Immediate: extended to DATA_W, sign or zero per ctl_ext_op.
- Operand B: ex_operand_b = ctl_alu_src ? ext_imm : GPR[rt].
- Destination: ex_dst = ctl_link ? NUM_REGS-1 : (ctl_reg_dst ? rd : rt).
- GPR file: NUM_REGS x DATA_W flops, all cleared by reset; written at the clk edge when wb_we=1.
- REG0_ZERO=1: index 0 writes are ignored and index 0 reads return 0.
- Bypass: when BYPASS=1, wb_we=1 and wb_addr equals the read index (and that index is not a zero-forced 0), the read returns wb_data in the same cycle. When BYPASS=0, the read returns the old value.
- Hazard: hz = ex_valid & ex_mem_rd & ex_reg_wr & (ex_dst!=0 | !REG0_ZERO) & (ex_dst==rs | (ex_dst==rt & !ctl_alu_src)) & if_valid.
- Advance condition: adv = ex_ready | !ex_valid.
- Handshake: if_ready = flush | (adv & !hz). A transfer occurs when if_valid & if_ready & !flush, and loads the ID/EX register with ex_valid<=1.
- adv & !transfer: ex_valid<=0 (bubble; a hazard therefore inserts exactly one bubble).
- !adv: the register holds all values; outputs remain stable while ex_valid & !ex_ready.
- Flush (highest priority): ex_valid<=0 at the next edge. The ID instruction is consumed (if_ready=1) and discarded. Writeback is still honoured.
- stall_count: increments on each cycle with hz & adv & !flush; saturates at all-ones.
- Reset (asynchronous, any time, including mid-stall): ex_valid=0, all ex_* data outputs=0, stall_count=0, GPRs=0. Pending state is lost.
- Latency: 1 cycle from if transfer to ex_valid.

Decomposition:
- Package id_pipe_pkg: AW function (clog2), link-register constant, ID/EX payload struct (operands, dst, controls, pc).
- Sub-module gpr_file_bypass (parametrised: DATA_W, NUM_REGS, REG0_ZERO, BYPASS; 2 read ports, 1 write port).
- Hazard logic, immediate extension and the pipeline register remain in id_stage_pipe.

Test Plan:
- Reset, then write GPR5=0x1234_5678. Issue instr with rs=5, ctl_alu_src=1, ctl_ext_op=1, imm=0xFFF0 -> next cycle ex_valid=1, a=0x12345678, b=0xFFFFFFF0. With ctl_ext_op=0 -> b=0x0000FFF0.
- Bypass: wb_we=1, wb_addr=7, wb_data=0xAA in the same cycle as a read of rs=7 -> a=0xAA. With BYPASS=0 -> a=old GPR7 (0). Write to R0 with 0xFF -> reads return 0.
- Load-use: load with dst=3 in EX, next instr rs=3 -> if_ready=0 for 1 cycle, a bubble (ex_valid=0) is inserted, then the instr issues. stall_count=1. Same case with rt=3 and ctl_alu_src=1 -> no stall.
- Backpressure: ex_ready=0 for 3 cycles -> ex_* outputs stable, if_ready=0. Then ex_ready=1 -> the next instr loads. No loss or duplication across 10 random-stall instrs (scoreboard).
- Flush during hazard stall -> if_ready=1, ex_valid=0 next cycle, stall_count unchanged. ctl_link=1 -> ex_dst=31.
- Assert reset mid-stream with ex_valid=1 -> ex_valid and stall_count drop to 0 immediately (asynchronously). GPR reads return 0 after release.

Source files
------------

// File: rtl/id_pipe_pkg.sv
// Shared definitions for the pipelined decode stage: index-width helpers and the
// control/PC part of the ID/EX payload.
package id_pipe_pkg;

  localparam int unsigned FieldW = 5;
  localparam int unsigned ImmW   = 16;
  localparam int unsigned PcW    = 32;

  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int unsigned link_reg(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

  typedef struct packed {
    logic           reg_wr;
    logic           mem_rd;
    logic [PcW-1:0] pc;
  } id_ex_ctl_t;

endpackage

// File: rtl/gpr_file_bypass.sv
// Flop-based register file, two read ports and one write port, with optional
// zero register and same-cycle write-to-read forwarding.
module gpr_file_bypass
  import id_pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter bit          REG0_ZERO = 1'b1,
  parameter bit          BYPASS    = 1'b1,
  localparam int unsigned AW       = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wr_en;
  logic              w_zero_a, w_zero_b;
  logic              w_fwd_a, w_fwd_b;

  assign w_wr_en  = i_we && !(REG0_ZERO && (i_waddr == '0));

  assign w_zero_a = REG0_ZERO && (i_raddr_a == '0);
  assign w_zero_b = REG0_ZERO && (i_raddr_b == '0);
  assign w_fwd_a  = BYPASS && i_we && (i_waddr == i_raddr_a);
  assign w_fwd_b  = BYPASS && i_we && (i_waddr == i_raddr_b);

  // Zero forcing wins over forwarding so a write to r0 never leaks out.
  assign o_rdata_a = w_zero_a ? '0 : (w_fwd_a ? i_wdata : r_mem[i_raddr_a]);
  assign o_rdata_b = w_zero_b ? '0 : (w_fwd_b ? i_wdata : r_mem[i_raddr_b]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem <= '{default: '0};
    end else if (w_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: field extraction, GPR read with bypass, operand build,
// load-use hazard detection and a valid/ready ID/EX register.
module id_stage_pipe
  import id_pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter bit          REG0_ZERO   = 1'b1,
  parameter bit          BYPASS      = 1'b1,
  parameter int unsigned STALL_CNT_W = 16,
  localparam int unsigned AW         = addr_w(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [0:31]            if_instr,
  input  logic [0:31]            if_pc,
  input  logic                   ctl_alu_src,
  input  logic                   ctl_ext_op,
  input  logic                   ctl_imm_zero,
  input  logic                   ctl_reg_dst,
  input  logic                   ctl_link,
  input  logic                   ctl_reg_wr,
  input  logic                   ctl_mem_rd,
  input  logic                   flush,
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [DATA_W-1:0]      ex_operand_a,
  output logic [DATA_W-1:0]      ex_operand_b,
  output logic [DATA_W-1:0]      ex_store_data,
  output logic [AW-1:0]          ex_dst,
  output logic                   ex_reg_wr,
  output logic                   ex_mem_rd,
  output logic [0:31]            ex_pc,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] store_data;
    logic [AW-1:0]     dst;
    id_ex_ctl_t        ctl;
  } id_ex_t;

  localparam logic [AW-1:0] LinkDst = AW'(link_reg(NUM_REGS));

  logic [FieldW-1:0]      w_rs_f, w_rt_f, w_rd_f;
  logic [AW-1:0]          w_rs, w_rt, w_rd, w_dst;
  logic [5:0]             w_unused_opcode;
  logic [ImmW-1:0]        w_imm16;
  logic [DATA_W-1:0]      w_ext_imm;
  logic [DATA_W-1:0]      w_gpr_a, w_gpr_b;
  logic                   w_hz, w_adv, w_xfer;
  id_ex_t                 w_next;

  id_ex_t                 r_q;
  logic                   r_valid;
  logic [STALL_CNT_W-1:0] r_stall;

  // Opcode is decoded externally and arrives through the ctl_* inputs.
  assign w_unused_opcode = if_instr[0:5];

  assign w_rs_f = if_instr[6:10];
  assign w_rt_f = if_instr[11:15];
  assign w_rd_f = if_instr[16:20];
  assign w_rs   = w_rs_f[AW-1:0];
  assign w_rt   = w_rt_f[AW-1:0];
  assign w_rd   = w_rd_f[AW-1:0];

  assign w_imm16   = ctl_imm_zero ? '0 : if_instr[16:31];
  assign w_ext_imm = ctl_ext_op ? DATA_W'($signed(w_imm16)) : DATA_W'(w_imm16);
  assign w_dst     = ctl_link ? LinkDst : (ctl_reg_dst ? w_rd : w_rt);

  gpr_file_bypass #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .REG0_ZERO (REG0_ZERO),
    .BYPASS    (BYPASS)
  ) u_gpr (
    .clk       (clk),
    .reset     (reset),
    .i_we      (wb_we),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_gpr_a),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_gpr_b)
  );

  // A load in EX whose result the ID instruction needs costs one bubble.
  assign w_hz = r_valid && r_q.ctl.mem_rd && r_q.ctl.reg_wr &&
                ((r_q.dst != '0) || !REG0_ZERO) &&
                ((r_q.dst == w_rs) || ((r_q.dst == w_rt) && !ctl_alu_src)) && if_valid;

  assign w_adv    = ex_ready || !r_valid;
  assign if_ready = flush || (w_adv && !w_hz);
  assign w_xfer   = if_valid && if_ready && !flush;

  always_comb begin
    w_next            = '0;
    w_next.operand_a  = w_gpr_a;
    w_next.operand_b  = ctl_alu_src ? w_ext_imm : w_gpr_b;
    w_next.store_data = w_gpr_b;
    w_next.dst        = w_dst;
    w_next.ctl.reg_wr = ctl_reg_wr;
    w_next.ctl.mem_rd = ctl_mem_rd;
    w_next.ctl.pc     = if_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_q     <= '0;
      r_stall <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_valid <= w_xfer;
        if (w_xfer) begin
          r_q <= w_next;
        end
      end
      if (w_hz && w_adv && !flush && (r_stall != {STALL_CNT_W{1'b1}})) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_operand_a  = r_q.operand_a;
  assign ex_operand_b  = r_q.operand_b;
  assign ex_store_data = r_q.store_data;
  assign ex_dst        = r_q.dst;
  assign ex_reg_wr     = r_q.ctl.reg_wr;
  assign ex_mem_rd     = r_q.ctl.mem_rd;
  assign ex_pc         = r_q.ctl.pc;
  assign stall_count   = r_stall;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed vector table, hand-written hazard/flush/reset
// sequences and a randomized scoreboard run against a behavioural model.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        ctl_alu_src, ctl_ext_op, ctl_imm_zero, ctl_reg_dst, ctl_link;
  logic        ctl_reg_wr, ctl_mem_rd, flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_a, ex_b, ex_st, ex_pc;
  logic [4:0]  ex_dst;
  logic        ex_reg_wr, ex_mem_rd;
  logic [15:0] stall_count;

  logic        nb_if_ready, nb_ex_valid, nb_reg_wr, nb_mem_rd;
  logic [31:0] nb_a, nb_b, nb_st, nb_pc;
  logic [4:0]  nb_dst;
  logic [1:0]  nb_stall;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk (clk), .reset (reset), .if_valid (if_valid), .if_ready (if_ready),
    .if_instr (if_instr), .if_pc (if_pc), .ctl_alu_src (ctl_alu_src),
    .ctl_ext_op (ctl_ext_op), .ctl_imm_zero (ctl_imm_zero), .ctl_reg_dst (ctl_reg_dst),
    .ctl_link (ctl_link), .ctl_reg_wr (ctl_reg_wr), .ctl_mem_rd (ctl_mem_rd),
    .flush (flush), .wb_we (wb_we), .wb_addr (wb_addr), .wb_data (wb_data),
    .ex_valid (ex_valid), .ex_ready (ex_ready), .ex_operand_a (ex_a),
    .ex_operand_b (ex_b), .ex_store_data (ex_st), .ex_dst (ex_dst),
    .ex_reg_wr (ex_reg_wr), .ex_mem_rd (ex_mem_rd), .ex_pc (ex_pc),
    .stall_count (stall_count)
  );

  id_stage_pipe #(.BYPASS (1'b0), .STALL_CNT_W (2)) dut_nb (
    .clk (clk), .reset (reset), .if_valid (if_valid), .if_ready (nb_if_ready),
    .if_instr (if_instr), .if_pc (if_pc), .ctl_alu_src (ctl_alu_src),
    .ctl_ext_op (ctl_ext_op), .ctl_imm_zero (ctl_imm_zero), .ctl_reg_dst (ctl_reg_dst),
    .ctl_link (ctl_link), .ctl_reg_wr (ctl_reg_wr), .ctl_mem_rd (ctl_mem_rd),
    .flush (flush), .wb_we (wb_we), .wb_addr (wb_addr), .wb_data (wb_data),
    .ex_valid (nb_ex_valid), .ex_ready (ex_ready), .ex_operand_a (nb_a),
    .ex_operand_b (nb_b), .ex_store_data (nb_st), .ex_dst (nb_dst),
    .ex_reg_wr (nb_reg_wr), .ex_mem_rd (nb_mem_rd), .ex_pc (nb_pc),
    .stall_count (nb_stall)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int exp_stalls = 0;

  typedef struct {
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        alu, ext, iz, rdst, lnk;
    logic [31:0] a, b, st;
    logic [4:0]  dst;
  } vec_t;

  typedef struct packed {
    logic [31:0] a, b, st, pc;
    logic [4:0]  dst;
    logic        rw, mr;
  } exp_t;

  vec_t        vecs[6];
  exp_t        q[$];
  logic [31:0] m_gpr[32];
  int          m_stalls = 0;
  int          n_iss = 0;
  int          n_cons = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {6'b0, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic alu, input logic ext,
                        input logic iz, input logic rdst, input logic lnk,
                        input logic rw, input logic mr);
    if_valid = 1'b1;  if_instr = ins;
    ctl_alu_src = alu; ctl_ext_op = ext; ctl_imm_zero = iz; ctl_reg_dst = rdst;
    ctl_link = lnk;   ctl_reg_wr = rw;   ctl_mem_rd = mr;
  endtask

  task automatic wr_gpr(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  // Load writing r3, then a consumer; the consumer must wait one bubble if it needs r3.
  task automatic load_use(input logic [4:0] rs, input logic [4:0] rt, input logic alu,
                          input bit stall);
    set_in(mk(5'd1, 5'd3, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("lu_load_valid", 32'(ex_valid), 32'd1);
    set_in(mk(rs, rt, 16'h0004), alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_if_ready", 32'(if_ready), 32'(!stall));
    tick();
    if (stall) begin
      exp_stalls++;
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      chk("lu_ready_after", 32'(if_ready), 32'd1);
      tick();
    end
    if_valid = 1'b0;
    chk("lu_issued", 32'(ex_valid), 32'd1);
    chk("lu_a", ex_a, (rs == 5'd3) ? 32'h0000_0033 : 32'h0000_0044);
    chk("lu_stall_count", 32'(stall_count), 32'(exp_stalls));
  endtask

  function automatic logic [31:0] rdv(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_we && wb_addr == idx) return wb_data;
    return m_gpr[idx];
  endfunction

  task automatic rand_cycle(input bit drain);
    exp_t        fr, e;
    bit          hold, hz, adv, rdy;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    if (drain) begin
      if_valid = 1'b0; ex_ready = 1'b1; wb_we = 1'b0;
    end else begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      if_pc = $urandom;
      ctl_alu_src = 1'($urandom_range(0, 1)); ctl_ext_op = 1'($urandom_range(0, 1));
      ctl_imm_zero = ($urandom_range(0, 5) == 0); ctl_reg_dst = 1'($urandom_range(0, 1));
      ctl_link = ($urandom_range(0, 7) == 0); ctl_reg_wr = 1'($urandom_range(0, 1));
      ctl_mem_rd = 1'($urandom_range(0, 1));
      ex_ready = ($urandom_range(0, 2) != 0);
      wb_we = ($urandom_range(0, 2) == 0); wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
    end
    #1;
    rs = if_instr[25:21];
    rt = if_instr[20:16];
    hold = (q.size() != 0);
    if (hold) fr = q[0];
    else fr = '0;
    hz = hold && fr.mr && fr.rw && fr.dst != 5'd0 &&
         (fr.dst == rs || (fr.dst == rt && !ctl_alu_src)) && if_valid;
    adv = !hold || ex_ready;
    rdy = adv && !hz;
    chk("rnd_ex_valid", 32'(ex_valid), 32'(hold));
    chk("rnd_if_ready", 32'(if_ready), 32'(rdy));
    if (hz && adv && m_stalls < 65535) m_stalls++;
    if (hold && ex_ready) begin
      chk("rnd_a", ex_a, fr.a);
      chk("rnd_b", ex_b, fr.b);
      chk("rnd_st", ex_st, fr.st);
      chk("rnd_dst", 32'(ex_dst), 32'(fr.dst));
      chk("rnd_pc", ex_pc, fr.pc);
      chk("rnd_ctl", 32'({ex_reg_wr, ex_mem_rd}), 32'({fr.rw, fr.mr}));
      void'(q.pop_front());
      n_cons++;
    end
    if (if_valid && rdy) begin
      imm = ctl_imm_zero ? 16'h0 : if_instr[15:0];
      e.a = rdv(rs);
      e.st = rdv(rt);
      e.b = !ctl_alu_src ? e.st : (ctl_ext_op ? {{16{imm[15]}}, imm} : {16'h0, imm});
      e.dst = ctl_link ? 5'd31 : (ctl_reg_dst ? if_instr[15:11] : rt);
      e.pc = if_pc; e.rw = ctl_reg_wr; e.mr = ctl_mem_rd;
      q.push_back(e);
      n_iss++;
    end
    if (wb_we && wb_addr != 5'd0) m_gpr[wb_addr] = wb_data;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd5, 5'd6, 16'hFFF0, 1, 1, 0, 0, 0, 32'h12345678, 32'hFFFFFFF0, 32'hCAFEBABE, 5'd6};
    vecs[1] = '{5'd5, 5'd6, 16'hFFF0, 1, 0, 0, 0, 0, 32'h12345678, 32'h0000FFF0, 32'hCAFEBABE, 5'd6};
    vecs[2] = '{5'd9, 5'd5, 16'h1800, 0, 1, 0, 1, 0, 32'h00000042, 32'h12345678, 32'h12345678, 5'd3};
    vecs[3] = '{5'd0, 5'd9, 16'hFFFF, 1, 1, 1, 0, 0, 32'h00000000, 32'h00000000, 32'h00000042, 5'd9};
    vecs[4] = '{5'd6, 5'd0, 16'h7FFF, 1, 1, 0, 1, 1, 32'hCAFEBABE, 32'h00007FFF, 32'h00000000, 5'd31};
    vecs[5] = '{5'd5, 5'd9, 16'h8000, 1, 1, 0, 1, 0, 32'h12345678, 32'hFFFF8000, 32'h00000042, 5'd16};

    reset = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
    ctl_alu_src = 0; ctl_ext_op = 0; ctl_imm_zero = 0; ctl_reg_dst = 0; ctl_link = 0;
    ctl_reg_wr = 0; ctl_mem_rd = 0; wb_we = 0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_a", ex_a, 32'd0);
    chk("rst_b", ex_b, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);

    wr_gpr(5'd5, 32'h12345678);
    wr_gpr(5'd6, 32'hCAFEBABE);
    wr_gpr(5'd9, 32'h00000042);
    wr_gpr(5'd3, 32'h00000033);
    wr_gpr(5'd4, 32'h00000044);

    for (int i = 0; i < 6; i++) begin
      set_in(mk(vecs[i].rs, vecs[i].rt, vecs[i].imm), vecs[i].alu, vecs[i].ext, vecs[i].iz,
             vecs[i].rdst, vecs[i].lnk, 1'b0, 1'b0);
      if_pc = 32'h1000 + 32'(i * 4);
      #1;
      chk("vec_if_ready", 32'(if_ready), 32'd1);
      tick();
      if_valid = 1'b0;
      chk("vec_valid", 32'(ex_valid), 32'd1);
      chk("vec_a", ex_a, vecs[i].a);
      chk("vec_b", ex_b, vecs[i].b);
      chk("vec_st", ex_st, vecs[i].st);
      chk("vec_dst", 32'(ex_dst), 32'(vecs[i].dst));
      chk("vec_pc", ex_pc, 32'h1000 + 32'(i * 4));
    end

    // Same-cycle writeback to the read index.
    set_in(mk(5'd7, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hAA;
    tick();
    wb_we = 1'b0;
    chk("byp_a", ex_a, 32'hAA);
    chk("nobyp_a", nb_a, 32'h0);
    tick();
    chk("nobyp_written", nb_a, 32'hAA);
    set_in(mk(5'd0, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
    tick();
    wb_we = 1'b0;
    chk("r0_byp_a", ex_a, 32'h0);
    chk("r0_byp_st", ex_st, 32'h0);
    tick();
    if_valid = 1'b0;
    chk("r0_stored_a", ex_a, 32'h0);
    chk("r0_nb_a", nb_a, 32'h0);

    load_use(5'd3, 5'd4, 1'b1, 1'b1);
    load_use(5'd4, 5'd3, 1'b1, 1'b0);
    load_use(5'd4, 5'd3, 1'b0, 1'b1);
    load_use(5'd3, 5'd4, 1'b1, 1'b1);
    load_use(5'd3, 5'd4, 1'b0, 1'b1);
    chk("nb_stall_sat", 32'(nb_stall), 32'd3);

    // Backpressure: EX holds A while B waits.
    set_in(mk(5'd5, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(mk(5'd6, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_if_ready", 32'(if_ready), 32'd0);
      chk("bp_valid", 32'(ex_valid), 32'd1);
      chk("bp_a_stable", ex_a, 32'h12345678);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(if_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    chk("bp_next_a", ex_a, 32'hCAFEBABE);

    // Flush while the load-use stall is pending.
    set_in(mk(5'd1, 5'd3, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(mk(5'd3, 5'd4, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fl_hz_ready", 32'(if_ready), 32'd0);
    flush = 1'b1;
    #1;
    chk("fl_if_ready", 32'(if_ready), 32'd1);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("fl_ex_valid", 32'(ex_valid), 32'd0);
    chk("fl_stall", 32'(stall_count), 32'(exp_stalls));

    // Asynchronous reset mid-stream.
    set_in(mk(5'd5, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if_valid = 1'b0;
    chk("ar_pre_valid", 32'(ex_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(ex_valid), 32'd0);
    chk("ar_stall", 32'(stall_count), 32'd0);
    chk("ar_a", ex_a, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    set_in(mk(5'd5, 5'd6, 16'h0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if_valid = 1'b0;
    chk("ar_gpr_a", ex_a, 32'd0);
    chk("ar_gpr_st", ex_st, 32'd0);
    tick();

    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_stalls = 0;
    for (int i = 0; i < 400; i++) rand_cycle(1'b0);
    for (int i = 0; i < 5; i++) rand_cycle(1'b1);
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_enough", 32'(n_iss >= 10), 32'd1);
    chk("rnd_no_loss", 32'(n_cons), 32'(n_iss));
    chk("rnd_stall_count", 32'(stall_count), 32'(m_stalls));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
